// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-client SPI arbiter: state encoding,
// client indices, guard counter width and the toggle-handshake helper.
package spi_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_OWNED = ST_OWNED,
        S_XFER  = ST_XFER,
        S_GUARD = ST_GUARD
    } arb_state_e;

    localparam logic CL_FLASH = 1'b0;
    localparam logic CL_MMC64 = 1'b1;

    localparam int unsigned GUARD_W = 4;

    // A toggle handshake has outstanding work while the two sides differ.
    function automatic logic pending(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/spi_client_arbiter.sv
// Two-client arbiter in front of the shared SPI byte master. Ownership is
// held for a whole device-select window plus a guard period, so bytes of
// different devices never interleave on the master.
module spi_client_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned guard_cycles = 4,
    parameter bit          first_owner  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       c0_req,
    output logic       c0_ack,
    input  logic [7:0] c0_d,
    input  logic       c0_speed,
    input  logic       c0_cs_n,
    input  logic       c1_req,
    output logic       c1_ack,
    input  logic [7:0] c1_d,
    input  logic       c1_speed,
    input  logic       c1_cs_n,
    output logic       m_req,
    input  logic       m_ack,
    output logic [7:0] m_d,
    output logic       m_speed,
    output logic       owner,
    output logic       busy,
    output logic       collision
);

    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(guard_cycles);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               granted_q, granted_d;
    logic               m_req_q, m_req_d;
    logic [7:0]         m_d_q, m_d_d;
    logic               m_speed_q, m_speed_d;
    logic               c0_ack_q, c0_ack_d;
    logic               c1_ack_q, c1_ack_d;
    logic               busy_q, busy_d;
    logic               collision_q, collision_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;

    logic c0_pend_s, c1_pend_s;
    logic c0_cand_s, c1_cand_s;
    logic own_pend_s, own_cs_low_s;
    logic m_idle_s;
    logic tie_pick_s, idle_win_s, idle_win_pend_s;
    logic launch_s;

    assign c0_pend_s = pending(c0_req, c0_ack_q);
    assign c1_pend_s = pending(c1_req, c1_ack_q);
    assign c0_cand_s = c0_pend_s | ~c0_cs_n;
    assign c1_cand_s = c1_pend_s | ~c1_cs_n;

    assign own_pend_s   = (owner_q == CL_MMC64) ? c1_pend_s : c0_pend_s;
    assign own_cs_low_s = (owner_q == CL_MMC64) ? ~c1_cs_n : ~c0_cs_n;

    // Master is free only once its ack has caught up with our request,
    // which also holds off the first launch after a mid-transfer reset.
    assign m_idle_s = (m_ack == m_req_q);

    // Until the first grant the "last owner" is the complement of first_owner.
    assign tie_pick_s      = granted_q ? ~owner_q : first_owner;
    assign idle_win_s      = (c0_cand_s & c1_cand_s) ? tie_pick_s : c1_cand_s;
    assign idle_win_pend_s = (idle_win_s == CL_MMC64) ? c1_pend_s : c0_pend_s;

    // Next-state, grant, handshake and guard-counter logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        granted_d   = granted_q;
        m_req_d     = m_req_q;
        m_d_d       = m_d_q;
        m_speed_d   = m_speed_q;
        c0_ack_d    = c0_ack_q;
        c1_ack_d    = c1_ack_q;
        guard_cnt_d = guard_cnt_q;
        launch_s    = 1'b0;
        collision_d = collision_q | (~c0_cs_n & ~c1_cs_n);

        case (state_q)
            S_IDLE: begin
                if (c0_cand_s | c1_cand_s) begin
                    if (idle_win_pend_s) begin
                        if (m_idle_s) begin
                            owner_d   = idle_win_s;
                            granted_d = 1'b1;
                            launch_s  = 1'b1;
                            state_d   = S_XFER;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        owner_d   = idle_win_s;
                        granted_d = 1'b1;
                        state_d   = S_OWNED;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OWNED: begin
                if (own_pend_s) begin
                    if (m_idle_s) begin
                        launch_s = 1'b1;
                        state_d  = S_XFER;
                    end else begin
                        state_d = S_OWNED;
                    end
                end else if (!own_cs_low_s) begin
                    guard_cnt_d = GUARD_LOAD;
                    state_d     = S_GUARD;
                end else begin
                    state_d = S_OWNED;
                end
            end
            S_XFER: begin
                if (m_idle_s) begin
                    if (owner_q == CL_FLASH) begin
                        c0_ack_d = ~c0_ack_q;
                    end else begin
                        c1_ack_d = ~c1_ack_q;
                    end
                    state_d = S_OWNED;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_GUARD: begin
                if (own_pend_s | own_cs_low_s) begin
                    guard_cnt_d = {GUARD_W{1'b0}};
                    state_d     = S_OWNED;
                end else if (guard_cnt_q <= 4'd1) begin
                    guard_cnt_d = {GUARD_W{1'b0}};
                    state_d     = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 4'd1;
                    state_d     = S_GUARD;
                end
            end
            default: begin
                guard_cnt_d = {GUARD_W{1'b0}};
                state_d     = S_IDLE;
            end
        endcase

        // Client byte and speed are captured only on the launch edge.
        if (launch_s) begin
            m_req_d   = ~m_req_q;
            m_d_d     = (owner_d == CL_MMC64) ? c1_d : c0_d;
            m_speed_d = (owner_d == CL_MMC64) ? c1_speed : c0_speed;
        end else begin
            m_req_d   = m_req_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= first_owner;
            granted_q   <= 1'b0;
            m_req_q     <= 1'b0;
            m_d_q       <= 8'h00;
            m_speed_q   <= 1'b0;
            c0_ack_q    <= 1'b0;
            c1_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            guard_cnt_q <= {GUARD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            granted_q   <= granted_d;
            m_req_q     <= m_req_d;
            m_d_q       <= m_d_d;
            m_speed_q   <= m_speed_d;
            c0_ack_q    <= c0_ack_d;
            c1_ack_q    <= c1_ack_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign c0_ack    = c0_ack_q;
    assign c1_ack    = c1_ack_q;
    assign m_req     = m_req_q;
    assign m_d       = m_d_q;
    assign m_speed   = m_speed_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_spi_client_arbiter.sv
// Directed bench for spi_client_arbiter: a cycle table for a single transfer,
// guard release and collision, plus hand sequences for deferral, ties,
// guard abort and reset in the middle of a transfer.
module tb_spi_client_arbiter;

    localparam int unsigned GUARD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       c0_req, c0_ack, c0_speed, c0_cs_n;
    logic       c1_req, c1_ack, c1_speed, c1_cs_n;
    logic [7:0] c0_d, c1_d, m_d;
    logic       m_req, m_ack, m_speed, owner, busy, collision;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_ack0, exp_ack1;

    always #5 clk = ~clk;

    spi_client_arbiter #(.guard_cycles(GUARD), .first_owner(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(c0_req), .c0_ack(c0_ack), .c0_d(c0_d), .c0_speed(c0_speed), .c0_cs_n(c0_cs_n),
        .c1_req(c1_req), .c1_ack(c1_ack), .c1_d(c1_d), .c1_speed(c1_speed), .c1_cs_n(c1_cs_n),
        .m_req(m_req), .m_ack(m_ack), .m_d(m_d), .m_speed(m_speed),
        .owner(owner), .busy(busy), .collision(collision)
    );

    typedef struct {
        logic       c0_req, c0_cs_n, c1_req, c1_cs_n, m_ack;
        logic [7:0] c0_d, c1_d;
        logic       e_m_req;
        logic [7:0] e_m_d;
        logic       e_m_speed, e_c0_ack, e_c1_ack, e_owner, e_busy, e_coll;
    } vec_t;

    vec_t tbl [0:20];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        c0_req   = 1'b0; c0_cs_n = 1'b1; c0_d = 8'h00; c0_speed = 1'b0;
        c1_req   = 1'b0; c1_cs_n = 1'b1; c1_d = 8'h00; c1_speed = 1'b0;
        m_ack    = 1'b0;
        exp_ack0 = 1'b0;
        exp_ack1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Wait (bounded) for a master request, check it, ack after lat cycles.
    task automatic serve(input string tag, input logic e_own, input logic [7:0] e_d,
                         input logic e_spd, input int lat);
        int waited = 0;
        while (m_req === m_ack && waited < 40) begin
            tick();
            waited++;
        end
        chk({tag, " launch"}, {7'd0, (m_req !== m_ack)}, 8'd1);
        chk({tag, " owner"}, {7'd0, owner}, {7'd0, e_own});
        chk({tag, " m_d"}, m_d, e_d);
        chk({tag, " m_speed"}, {7'd0, m_speed}, {7'd0, e_spd});
        repeat (lat) tick();
        m_ack = m_req;
        if (e_own) exp_ack1 = ~exp_ack1;
        else       exp_ack0 = ~exp_ack0;
        tick();
        chk({tag, " c0_ack"}, {7'd0, c0_ack}, {7'd0, exp_ack0});
        chk({tag, " c1_ack"}, {7'd0, c1_ack}, {7'd0, exp_ack1});
    endtask

    task automatic wait_idle(input string tag);
        int waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk({tag, " idle"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        // c0_req c0_cs_n c1_req c1_cs_n m_ack c0_d c1_d | m_req m_d m_speed c0_ack c1_ack owner busy coll
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 8'h03,8'hA5, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'h03,8'hA5, 1'b1,8'h03,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'h55,8'hA5, 1'b1,8'h03,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'h55,8'hA5, 1'b1,8'h03,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'h55,8'hA5, 1'b1,8'h03,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'h55,8'hA5, 1'b1,8'h03,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 8'h55,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 8'h77,8'hA5, 1'b1,8'h03,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
        tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b1, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
        tbl[15] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
        tbl[16] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
        tbl[17] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
        tbl[18] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
        tbl[19] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
        tbl[20] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 8'h77,8'hA5, 1'b0,8'hA5,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};

        // ---- A: table-driven single transfer, guard release, collision ----
        do_reset();
        c0_speed = 1'b1;
        c1_speed = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            c0_req = tbl[i].c0_req; c0_cs_n = tbl[i].c0_cs_n;
            c1_req = tbl[i].c1_req; c1_cs_n = tbl[i].c1_cs_n;
            m_ack  = tbl[i].m_ack;  c0_d = tbl[i].c0_d; c1_d = tbl[i].c1_d;
            tick();
            chk($sformatf("A%0d m_req", i),   {7'd0, m_req},     {7'd0, tbl[i].e_m_req});
            chk($sformatf("A%0d m_d", i),     m_d,               tbl[i].e_m_d);
            chk($sformatf("A%0d m_speed", i), {7'd0, m_speed},   {7'd0, tbl[i].e_m_speed});
            chk($sformatf("A%0d c0_ack", i),  {7'd0, c0_ack},    {7'd0, tbl[i].e_c0_ack});
            chk($sformatf("A%0d c1_ack", i),  {7'd0, c1_ack},    {7'd0, tbl[i].e_c1_ack});
            chk($sformatf("A%0d owner", i),   {7'd0, owner},     {7'd0, tbl[i].e_owner});
            chk($sformatf("A%0d busy", i),    {7'd0, busy},      {7'd0, tbl[i].e_busy});
            chk($sformatf("A%0d collision", i), {7'd0, collision}, {7'd0, tbl[i].e_coll});
        end

        // ---- B: reset values, then deferral of client 1 behind client 0 ----
        do_reset();
        #1;
        chk("B rst collision", {7'd0, collision}, 8'd0);
        chk("B rst m_req", {7'd0, m_req}, 8'd0);
        chk("B rst owner", {7'd0, owner}, 8'd0);
        chk("B rst busy", {7'd0, busy}, 8'd0);
        chk("B rst m_d", m_d, 8'h00);
        c0_cs_n = 1'b0; c0_d = 8'h11; c0_speed = 1'b0;
        c0_req  = ~c0_req;
        serve("B c0", 1'b0, 8'h11, 1'b0, 2);
        c1_d = 8'h22; c1_speed = 1'b1;
        c1_req = ~c1_req;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("B defer m_req", {7'd0, m_req}, {7'd0, m_ack});
            chk("B defer c1_ack", {7'd0, c1_ack}, 8'd0);
        end
        c0_cs_n = 1'b1;
        for (int i = 0; i < GUARD + 1; i++) begin
            tick();
            chk("B guard hold", {7'd0, m_req}, {7'd0, m_ack});
        end
        tick();
        chk("B grant edge", {7'd0, m_req}, {7'd0, ~m_ack});
        chk("B grant owner", {7'd0, owner}, 8'd1);
        chk("B grant m_d", m_d, 8'h22);
        chk("B grant speed", {7'd0, m_speed}, 8'd1);
        repeat (3) tick();
        chk("B c1_ack early", {7'd0, c1_ack}, 8'd0);
        m_ack = m_req;
        tick();
        chk("B c1_ack", {7'd0, c1_ack}, 8'd1);

        // ---- C: tie-break, first_owner first, then not-last-owner ----
        do_reset();
        c0_d = 8'h31; c0_speed = 1'b1; c1_d = 8'h32; c1_speed = 1'b0;
        c0_req = ~c0_req; c1_req = ~c1_req;
        serve("C tie1 first", 1'b0, 8'h31, 1'b1, 1);
        serve("C tie1 second", 1'b1, 8'h32, 1'b0, 1);
        wait_idle("C after tie1");
        c0_d = 8'h33;
        c0_req = ~c0_req;
        serve("C solo c0", 1'b0, 8'h33, 1'b1, 0);
        wait_idle("C after solo");
        c0_d = 8'h34; c1_d = 8'h35;
        c0_req = ~c0_req; c1_req = ~c1_req;
        serve("C tie2 first", 1'b1, 8'h35, 1'b0, 1);
        serve("C tie2 second", 1'b0, 8'h34, 1'b1, 1);

        // ---- D: guard aborted by owner re-selecting its device ----
        do_reset();
        c0_cs_n = 1'b0; c0_d = 8'h41;
        c0_req = ~c0_req;
        serve("D c0", 1'b0, 8'h41, 1'b0, 1);
        c1_d = 8'h42; c1_speed = 1'b1;
        c1_req = ~c1_req;
        c0_cs_n = 1'b1;
        repeat (3) tick();
        c0_cs_n = 1'b0;
        for (int i = 0; i < GUARD + 3; i++) begin
            tick();
            chk("D abort busy", {7'd0, busy}, 8'd1);
            chk("D abort owner", {7'd0, owner}, 8'd0);
            chk("D abort m_req", {7'd0, m_req}, {7'd0, m_ack});
            chk("D abort c1_ack", {7'd0, c1_ack}, 8'd0);
        end
        c0_cs_n = 1'b1;
        serve("D c1 later", 1'b1, 8'h42, 1'b1, 0);

        // ---- E: reset while waiting for the master ack ----
        do_reset();
        c0_cs_n = 1'b0; c0_d = 8'h51;
        c0_req = 1'b1;
        tick();
        chk("E launch", {7'd0, m_req}, 8'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("E async m_req", {7'd0, m_req}, 8'd0);
        chk("E async c0_ack", {7'd0, c0_ack}, 8'd0);
        chk("E async busy", {7'd0, busy}, 8'd0);
        chk("E async m_d", m_d, 8'h00);
        m_ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("E hold m_req", {7'd0, m_req}, 8'd0);
            chk("E hold busy", {7'd0, busy}, 8'd0);
            chk("E hold c0_ack", {7'd0, c0_ack}, 8'd0);
        end
        m_ack = 1'b0;
        tick();
        chk("E relaunch", {7'd0, m_req}, 8'd1);
        chk("E relaunch m_d", m_d, 8'h51);
        m_ack = 1'b1;
        tick();
        chk("E single ack", {7'd0, c0_ack}, 8'd1);
        repeat (3) tick();
        chk("E no dup", {7'd0, m_req}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_client_arbiter.md
Name: spi_client_arbiter

Overview:
- Sits directly upstream of the shared SPI byte master, replacing the static rom_load_done mux.
- Arbitrates two SPI clients (client 0 = NOR flash loader, client 1 = MMC64 register block) onto one master using toggle req/ack handshakes.
- Ownership is locked per device-select window, so byte transfers from different devices never interleave.
- Broadcasts master result byte to both clients; only the owner is acked.

Parameters:
- guard_cycles, 4, idle clk cycles after owner's cs_n rises before ownership may change (1..15).
- first_owner, 0, client that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- c0_req  in  1  client 0 toggle request
- c0_ack  out  1  client 0 toggle acknowledge
- c0_d  in  8  client 0 transmit byte
- c0_speed  in  1  client 0 speed select (1 = fast)
- c0_cs_n  in  1  client 0 device select, observed only
- c1_req, c1_ack, c1_d, c1_speed, c1_cs_n  as client 0, for client 1
- m_req  out  1  master toggle request
- m_ack  in  1  master toggle acknowledge (same clock domain)
- m_d  out  8  byte to master, registered
- m_speed  out  1  speed to master, registered
- owner  out  1  current/last owner index
- busy  out  1  high in any state other than IDLE
- collision  out  1  sticky: both cs_n low in the same cycle

Behaviour:
- Pending: client i is pending while ci_req != ci_ack.
- Reset values: m_req=0, m_d=0, m_speed=0, c0_ack=0, c1_ack=0, owner=first_owner, busy=0, collision=0, state=IDLE, guard counter=0.

States:
- IDLE
  - Exactly one client pending or cs_n low: grant it.
  - Both candidates in the same cycle: grant the client that is not `owner`. Before any grant, the "last owner" is the complement of first_owner, so first_owner wins.
  - Grant with a pending request: go to XFER; otherwise go to OWNED.
- OWNED
  - Owner pending: go to XFER.
  - Owner cs_n high and not pending: go to GUARD, counter loaded with guard_cycles.
- XFER
  - On the entry edge: m_d <= owner d, m_speed <= owner speed, m_req <= ~m_req.
  - Wait while m_ack != m_req.
  - On the first cycle with m_ack == m_req: toggle owner's ack, go to OWNED.
- GUARD
  - Counter decrements each cycle.
  - Owner pending or cs_n low: return to OWNED (abort guard).
  - Counter reaches 0: go to IDLE.

Latency:
- Pending request seen in IDLE at edge N: m_req toggles at edge N+1.
- m_ack match at edge M: ci_ack toggles at edge M+1.
- Back-to-back owner requests: at most 2 idle cycles between master transfers.

Non-owner handling:
- A non-owner request stays pending (ack unchanged) until the owner leaves GUARD.
- No request is ever dropped or duplicated.
- ci_d/ci_speed are sampled only on the XFER entry edge; later client changes are ignored.

collision:
- Set when c0_cs_n=0 and c1_cs_n=0 in the same cycle; cleared only by reset.
- Arbitration is unaffected.

Reset mid-transfer:
- All outputs return to reset values asynchronously.
- The first transfer after reset must not start until m_ack == m_req; stay in IDLE while they differ.
- No client ack is generated for the aborted transfer.

Decomposition:
- Shared package `spi_arb_pkg`:
  - state encoding localparams ST_IDLE/ST_OWNED/ST_XFER/ST_GUARD
  - client index constants CL_FLASH=0, CL_MMC64=1
  - guard counter width (4)
- Single module; no sub-module. Per-client pending compare is two lines and does not warrant one.

Test Plan:
- Single transfer: c0_req 0->1 with c0_d=8'h03, c0_cs_n=0 -> m_req toggles next cycle, m_d=8'h03. Master acks 5 cycles later -> c0_ack=1 one cycle after, owner=0.
- Deferral: client 0 owns with c0_cs_n=0; c1_req toggles -> m_req unchanged. Client 0 raises cs_n -> client 1 served exactly guard_cycles+2 cycles later, c1_ack toggles only after its own m_ack.
- Tie/round-robin: both requests in the same IDLE cycle after reset with first_owner=0 -> client 0 first. After release, repeat tie -> client 1 first.
- Guard abort: owner raises cs_n, then re-lowers it at guard count 2 -> returns to OWNED, pending client 1 not granted, busy stays 1.
- Collision: c0_cs_n=c1_cs_n=0 for one cycle -> collision=1 and remains 1 through later transfers until reset_n low.
- Reset mid-XFER: assert reset_n low while awaiting m_ack -> m_req=0, acks=0 immediately. Hold m_ack=1 after release -> no new m_req until m_ack returns to 0.
